// File: rtl/reg_commit_scheduler_if.sv
// Register-write bus between the MPU port and the register file.
// The scheduler is the slave: it takes MPU writes and drives commits.
interface reg_commit_scheduler_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  mpu_wr;
   logic [ADDR_WIDTH-1:0] mpu_addr;
   logic [1:0]            mpu_be;
   logic [DATA_WIDTH-1:0] mpu_data;
   logic                  reg_wr;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [1:0]            reg_be;
   logic [DATA_WIDTH-1:0] reg_data;

   modport master (
      output mpu_wr, mpu_addr, mpu_be, mpu_data,
      input  reg_wr, reg_addr, reg_be, reg_data
   );

   modport slave (
      input  mpu_wr, mpu_addr, mpu_be, mpu_data,
      output reg_wr, reg_addr, reg_be, reg_data
   );
endinterface

// File: rtl/reg_commit_scheduler.sv
// Queues MPU register writes and commits them in order, either at once
// or only while vblank is high, with a sticky flag for dropped writes.
module reg_commit_scheduler #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   reg_commit_scheduler_if.slave    bus,
   input  logic                     vblank,
   input  logic                     sync_en,
   input  logic                     clr_overflow,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     full,
   output logic                     overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DRAIN
   } state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [1:0]            be;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   state_t        state;
   state_t        state_nx;
   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [PW:0]   count_nx;
   logic          commit_ok;
   logic          push;
   logic          pop;
   logic          drop;

   assign commit_ok = vblank | ~sync_en;
   assign full      = (count == FULL_CNT);
   assign pending   = count;
   // Space is judged on the registered count, so a pop never frees
   // room for a write landing on the same edge.
   assign push      = bus.mpu_wr & ~full;
   assign drop      = bus.mpu_wr & full;

   // Pop decision, next occupancy and next FSM state.
   always_comb begin
      pop      = 1'b0;
      count_nx = count;
      state_nx = state;
      if (state == DRAIN && commit_ok && count != '0)
         pop = 1'b1;
      case ({push, pop})
         2'b10:   count_nx = count + 1'b1;
         2'b01:   count_nx = count - 1'b1;
         default: count_nx = count;
      endcase
      unique case (state)
         IDLE: begin
            if (push)
               state_nx = WAIT;
         end
         WAIT: begin
            if (commit_ok)
               state_nx = DRAIN;
         end
         DRAIN: begin
            if (count_nx == '0)
               state_nx = IDLE;
            else if (!commit_ok)
               state_nx = WAIT;
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM, pointers, occupancy, overflow flag and the commit register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         bus.reg_wr   <= 1'b0;
         bus.reg_addr <= '0;
         bus.reg_be   <= '0;
         bus.reg_data <= '0;
      end else begin
         state      <= state_nx;
         count      <= count_nx;
         bus.reg_wr <= pop;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr       <= rd_ptr + 1'b1;
            bus.reg_addr <= mem[rd_ptr].addr;
            bus.reg_be   <= mem[rd_ptr].be;
            bus.reg_data <= mem[rd_ptr].data;
         end
         // A drop wins over a coincident clear so no loss goes unseen.
         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

   // Queue storage; contents need no reset since pointers gate them.
   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wr_ptr] <= '{addr: bus.mpu_addr,
                          be:   bus.mpu_be,
                          data: bus.mpu_data};
   end
endmodule

// File: tb/tb_reg_commit_scheduler.sv
// Bench for reg_commit_scheduler: vector table for single writes plus
// sequences for deferral, overflow, vblank loss and reset mid-drain.
module tb_reg_commit_scheduler;
   logic       clk;
   logic       reset;
   logic       vblank;
   logic       sync_en;
   logic       clr_overflow;
   logic [2:0] pending;
   logic       full;
   logic       overflow;

   typedef struct packed {
      logic [7:0]  a;
      logic [1:0]  be;
      logic [15:0] d;
   } wr_t;

   typedef struct {
      logic        sync_en;
      logic        vblank;
      logic [7:0]  a;
      logic [1:0]  be;
      logic [15:0] d;
      logic        exp_wr;
      logic [2:0]  exp_pend;
   } vec_t;

   wr_t  sb [$];
   wr_t  last;
   int   checks;
   int   errors;
   int   wr_count;

   reg_commit_scheduler_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

   reg_commit_scheduler #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(16),
      .DEPTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .vblank(vblank),
      .sync_en(sync_en),
      .clr_overflow(clr_overflow),
      .pending(pending),
      .full(full),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Drive one write for one edge; expected commits go to the scoreboard.
   task automatic wr(input logic [7:0] a, input logic [1:0] be,
                     input logic [15:0] d, input bit acc);
      bus.mpu_wr   = 1'b1;
      bus.mpu_addr = a;
      bus.mpu_be   = be;
      bus.mpu_data = d;
      if (acc)
         sb.push_back('{a: a, be: be, d: d});
      @(negedge clk);
      bus.mpu_wr = 1'b0;
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++)
         @(negedge clk);
   endtask

   task automatic wait_empty(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pending != 3'd0 && n < 20);
      chk(nm, {29'd0, pending}, 32'd0);
   endtask

   task automatic clr_pulse();
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
   endtask

   // Commit monitor: each reg_wr must match the oldest expected write;
   // otherwise the committed fields must hold their last value.
   always @(negedge clk) begin
      if (reset) begin
         last = '0;
      end else if (bus.reg_wr) begin
         wr_count++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL commit_unexpected act=%0h exp=none",
                     {bus.reg_addr, bus.reg_be, bus.reg_data});
         end else begin
            last = sb.pop_front();
            chk("commit", {6'd0, bus.reg_addr, bus.reg_be, bus.reg_data},
                {6'd0, last});
         end
      end else begin
         chk("hold", {6'd0, bus.reg_addr, bus.reg_be, bus.reg_data},
             {6'd0, last});
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl [6];
      int         base;
      logic [5:0] pat;

      checks       = 0;
      errors       = 0;
      wr_count     = 0;
      last         = '0;
      reset        = 1'b1;
      vblank       = 1'b0;
      sync_en      = 1'b0;
      clr_overflow = 1'b0;
      bus.mpu_wr   = 1'b0;
      bus.mpu_addr = '0;
      bus.mpu_be   = '0;
      bus.mpu_data = '0;

      tbl[0] = '{1'b0, 1'b0, 8'h03, 2'b11, 16'h1234, 1'b1, 3'd0};
      tbl[1] = '{1'b0, 1'b1, 8'hFF, 2'b01, 16'hFFFF, 1'b1, 3'd0};
      tbl[2] = '{1'b1, 1'b1, 8'h00, 2'b10, 16'h0000, 1'b1, 3'd0};
      tbl[3] = '{1'b0, 1'b0, 8'hA5, 2'b00, 16'h5A5A, 1'b1, 3'd0};
      tbl[4] = '{1'b1, 1'b1, 8'h7E, 2'b11, 16'h8001, 1'b1, 3'd0};
      tbl[5] = '{1'b1, 1'b0, 8'h42, 2'b11, 16'hBEEF, 1'b0, 3'd1};

      cyc(2);
      chk("rst_pending", {29'd0, pending}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
      chk("rst_reg_addr", {24'd0, bus.reg_addr}, 32'd0);
      chk("rst_reg_be", {30'd0, bus.reg_be}, 32'd0);
      chk("rst_reg_data", {16'd0, bus.reg_data}, 32'd0);
      reset = 1'b0;
      cyc(1);

      for (int i = 0; i < 6; i++) begin
         sync_en = tbl[i].sync_en;
         vblank  = tbl[i].vblank;
         wr(tbl[i].a, tbl[i].be, tbl[i].d, 1'b1);
         chk("vec_pend_n", {29'd0, pending}, 32'd1);
         @(negedge clk);
         chk("vec_wr_n1", {31'd0, bus.reg_wr}, 32'd0);
         @(negedge clk);
         chk("vec_wr_n2", {31'd0, bus.reg_wr}, {31'd0, tbl[i].exp_wr});
         chk("vec_pend_n2", {29'd0, pending}, {29'd0, tbl[i].exp_pend});
      end
      vblank = 1'b1;
      wait_empty("flush_deferred");
      cyc(1);
      vblank = 1'b0;
      cyc(1);

      base = wr_count;
      wr(8'h00, 2'b11, 16'h1111, 1'b1);
      wr(8'h03, 2'b11, 16'h2222, 1'b1);
      wr(8'h04, 2'b11, 16'h3333, 1'b1);
      cyc(2);
      chk("defer_pending", {29'd0, pending}, 32'd3);
      chk("defer_no_wr", wr_count - base, 32'd0);
      vblank = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pat[i] = bus.reg_wr;
      end
      chk("defer_burst", {26'd0, pat}, 32'b001110);
      vblank = 1'b0;
      cyc(1);

      wr(8'h10, 2'b01, 16'hA001, 1'b1);
      wr(8'h11, 2'b10, 16'hA002, 1'b1);
      wr(8'h12, 2'b11, 16'hA003, 1'b1);
      wr(8'h13, 2'b11, 16'hA004, 1'b1);
      chk("ovf_before", {31'd0, overflow}, 32'd0);
      wr(8'h14, 2'b11, 16'hA005, 1'b0);
      chk("ovf_full", {31'd0, full}, 32'd1);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      chk("ovf_pending", {29'd0, pending}, 32'd4);
      clr_pulse();
      chk("ovf_clr", {31'd0, overflow}, 32'd0);
      chk("ovf_full_kept", {31'd0, full}, 32'd1);
      clr_overflow = 1'b1;
      wr(8'h15, 2'b11, 16'hA006, 1'b0);
      clr_overflow = 1'b0;
      chk("ovf_clr_vs_drop", {31'd0, overflow}, 32'd1);
      clr_pulse();
      chk("ovf_clr2", {31'd0, overflow}, 32'd0);

      base   = wr_count;
      vblank = 1'b1;
      cyc(3);
      vblank = 1'b0;
      cyc(3);
      chk("vbl_drop_wrs", wr_count - base, 32'd2);
      chk("vbl_drop_pend", {29'd0, pending}, 32'd2);
      vblank = 1'b1;
      wait_empty("vbl_resume");
      cyc(1);
      chk("vbl_resume_wrs", wr_count - base, 32'd4);
      vblank = 1'b0;
      cyc(1);

      wr(8'h20, 2'b11, 16'hB001, 1'b1);
      wr(8'h21, 2'b11, 16'hB002, 1'b1);
      wr(8'h22, 2'b11, 16'hB003, 1'b1);
      wr(8'h23, 2'b11, 16'hB004, 1'b1);
      vblank = 1'b1;
      @(negedge clk);
      chk("pp_pend_full", {29'd0, pending}, 32'd4);
      wr(8'h24, 2'b11, 16'hDEAD, 1'b0);
      chk("pp_pending", {29'd0, pending}, 32'd3);
      chk("pp_overflow", {31'd0, overflow}, 32'd1);
      chk("pp_reg_wr", {31'd0, bus.reg_wr}, 32'd1);
      wait_empty("pp_drain");
      cyc(1);
      vblank = 1'b0;
      clr_pulse();

      wr(8'h30, 2'b11, 16'hC001, 1'b1);
      wr(8'h31, 2'b11, 16'hC002, 1'b1);
      wr(8'h32, 2'b11, 16'hC003, 1'b1);
      wr(8'h33, 2'b11, 16'hC004, 1'b1);
      wr(8'h34, 2'b11, 16'hC005, 1'b0);
      chk("rd_ovf_pre", {31'd0, overflow}, 32'd1);
      vblank = 1'b1;
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!bus.reg_wr && n < 10);
         chk("rd_first_wr", {31'd0, bus.reg_wr}, 32'd1);
      end
      #1;
      sb.delete();
      reset        = 1'b1;
      bus.mpu_wr   = 1'b1;
      bus.mpu_addr = 8'h55;
      bus.mpu_data = 16'h5555;
      @(negedge clk);
      base = wr_count;
      chk("rd_pending", {29'd0, pending}, 32'd0);
      chk("rd_full", {31'd0, full}, 32'd0);
      chk("rd_overflow", {31'd0, overflow}, 32'd0);
      chk("rd_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
      chk("rd_reg_addr", {24'd0, bus.reg_addr}, 32'd0);
      chk("rd_reg_be", {30'd0, bus.reg_be}, 32'd0);
      chk("rd_reg_data", {16'd0, bus.reg_data}, 32'd0);
      #1;
      reset      = 1'b0;
      bus.mpu_wr = 1'b0;
      cyc(5);
      chk("rd_after_pend", {29'd0, pending}, 32'd0);
      chk("rd_after_wrs", wr_count - base, 32'd0);
      vblank = 1'b0;

      cyc(2);
      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
